// File: rtl/ddr_pkg.sv
// Shared constants and helpers for the DDR step judge.
package ddr_pkg;

  // Direction bit positions in button and arrow vectors.
  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_RIGHT = 2;
  localparam int unsigned DIR_LEFT  = 3;
  localparam int unsigned NUM_DIRS  = 4;

  // Points awarded per grade.
  localparam int unsigned PTS_PERFECT = 2;
  localparam int unsigned PTS_GOOD    = 1;

  // Running totals width.
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned COMBO_W = 8;

  // Judge state encoding.
  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_OPEN = 1'b1;

  // Outcome of the current cycle's judging.
  typedef enum logic [1:0] {
    GRADE_NONE,
    GRADE_PERFECT,
    GRADE_GOOD,
    GRADE_MISS
  } grade_e;

  function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a,
                                                       input int unsigned pts);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(pts);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] a);
    return (a == '1) ? a : a + COMBO_W'(1);
  endfunction

endpackage

// File: rtl/ddr_btn_filter.sv
// Per-bit debounce of raw button levels plus registered rising-edge detect.
module ddr_btn_filter #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned WIDTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] edge_o
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_q;

  // Count while raw disagrees with the filtered level; flip once stable long enough.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (raw_i[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Filter state, plus an edge pulse one cycle after the filtered level rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      prev_q  <= level_q;
      edge_q  <= level_q & ~prev_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_o = level_q;
  assign edge_o  = edge_q;

endmodule

// File: rtl/ddr_step_judge.sv
// Judges debounced button presses against sequencer arrows; keeps score and combo.
module ddr_step_judge
  import ddr_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 50000,
  parameter int unsigned WINDOW_CYCLES  = 15000000,
  parameter int unsigned PERFECT_CYCLES = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_DIRS-1:0] btn_lvl,
  input  logic                arrow_valid,
  input  logic [NUM_DIRS-1:0] arrow_mask,
  input  logic                clear,
  output logic                hit_perfect,
  output logic                hit_good,
  output logic                miss,
  output logic [SCORE_W-1:0]  score,
  output logic [COMBO_W-1:0]  combo,
  output logic                busy
);

  localparam int unsigned CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PERFECT = CNT_W'(PERFECT_CYCLES);

  logic [NUM_DIRS-1:0] level_unused;
  logic [NUM_DIRS-1:0] edges;

  logic [0:0]          state_q, state_d;
  logic [NUM_DIRS-1:0] target_q, target_d;
  logic [NUM_DIRS-1:0] hit_q, hit_d;
  logic [CNT_W-1:0]    count_q, count_d;
  grade_e              grade_d;
  logic                new_arrow, wrong, done, timeout;

  logic                perfect_q, good_q, miss_q;
  logic [SCORE_W-1:0]  score_q;
  logic [COMBO_W-1:0]  combo_q;

  ddr_btn_filter #(
    .DB_CYCLES(DB_CYCLES),
    .WIDTH    (NUM_DIRS)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (btn_lvl),
    .level_o(level_unused),
    .edge_o (edges)
  );

  // Window bookkeeping and the wrong > done > timeout decision.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    hit_d     = hit_q;
    count_d   = count_q;
    grade_d   = GRADE_NONE;
    new_arrow = arrow_valid && (arrow_mask != '0);
    wrong     = |(edges & ~target_q);
    done      = ((hit_q | edges) & target_q) == target_q;
    timeout   = (count_q == CNT_TIMEOUT);

    if (state_q == ST_OPEN) begin
      count_d = count_q + CNT_W'(1);
      // A replacing arrow claims this cycle's edges, so the old arrow sees
      // none: it cannot be wrong or newly done and therefore always misses.
      if (new_arrow) begin
        grade_d = GRADE_MISS;
      end else if (wrong) begin
        grade_d = GRADE_MISS;
      end else if (done) begin
        grade_d = (count_q < CNT_PERFECT) ? GRADE_PERFECT : GRADE_GOOD;
      end else if (timeout) begin
        grade_d = GRADE_MISS;
      end else begin
        hit_d = hit_q | edges;
      end
      if (grade_d != GRADE_NONE) begin
        state_d = ST_WAIT;
      end
    end

    if (new_arrow) begin
      state_d  = ST_OPEN;
      target_d = arrow_mask;
      hit_d    = edges;
      count_d  = '0;
    end
  end

  // Judge state, grade pulses and running totals; clear overrides the totals only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WAIT;
      target_q  <= '0;
      hit_q     <= '0;
      count_q   <= '0;
      perfect_q <= 1'b0;
      good_q    <= 1'b0;
      miss_q    <= 1'b0;
      score_q   <= '0;
      combo_q   <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      hit_q     <= hit_d;
      count_q   <= count_d;
      perfect_q <= (grade_d == GRADE_PERFECT);
      good_q    <= (grade_d == GRADE_GOOD);
      miss_q    <= (grade_d == GRADE_MISS);
      if (clear) begin
        score_q <= '0;
        combo_q <= '0;
      end else begin
        case (grade_d)
          GRADE_PERFECT: begin
            score_q <= sat_add_score(score_q, PTS_PERFECT);
            combo_q <= sat_inc_combo(combo_q);
          end
          GRADE_GOOD: begin
            score_q <= sat_add_score(score_q, PTS_GOOD);
            combo_q <= sat_inc_combo(combo_q);
          end
          GRADE_MISS: begin
            combo_q <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign hit_perfect = perfect_q;
  assign hit_good    = good_q;
  assign miss        = miss_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign busy        = (state_q == ST_OPEN);

endmodule

// File: tb/tb_ddr_step_judge.sv
// Scoreboard bench for ddr_step_judge with small debounce/window parameters.
module tb_ddr_step_judge;

  localparam int unsigned DB   = 4;
  localparam int unsigned WIN  = 100;
  localparam int unsigned PERF = 20;
  localparam logic [2:0] G_P = 3'b100;
  localparam logic [2:0] G_G = 3'b010;
  localparam logic [2:0] G_M = 3'b001;
  localparam int unsigned N_STREAM = 32770;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_lvl;
  logic        arrow_valid;
  logic [3:0]  arrow_mask;
  logic        clear;
  logic        hit_perfect, hit_good, miss;
  logic [15:0] score;
  logic [7:0]  combo;
  logic        busy;

  typedef struct {
    logic [2:0]  grade;
    logic [15:0] score;
    logic [7:0]  combo;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [15:0] m_score = '0;
  logic [7:0]  m_combo = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_step_judge #(
    .DB_CYCLES     (DB),
    .WINDOW_CYCLES (WIN),
    .PERFECT_CYCLES(PERF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_lvl    (btn_lvl),
    .arrow_valid(arrow_valid),
    .arrow_mask (arrow_mask),
    .clear      (clear),
    .hit_perfect(hit_perfect),
    .hit_good   (hit_good),
    .miss       (miss),
    .score      (score),
    .combo      (combo),
    .busy       (busy)
  );

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Model the totals and queue the pulse expected at posedge index 'at'.
  task automatic expect_pulse(input logic [2:0] g, input logic clr, input int unsigned at);
    int unsigned s;
    if (clr) begin
      m_score = '0;
      m_combo = '0;
    end else if (g == G_M) begin
      m_combo = '0;
    end else begin
      s = int'(m_score) + ((g == G_P) ? 2 : 1);
      m_score = (s > 65535) ? 16'hFFFF : 16'(s);
      m_combo = (m_combo == 8'hFF) ? 8'hFF : m_combo + 8'd1;
    end
    sb.push_back('{g, m_score, m_combo, at});
  endtask

  // Open an arrow, start holding 'press' from offset 'start'; the edge lands at start+5.
  task automatic press_arrow(input logic [3:0] mask, input logic [3:0] press,
                             input int unsigned start, input logic [2:0] g, input logic clr);
    int unsigned a;
    arrow_valid = 1'b1;
    arrow_mask  = mask;
    step(1);
    arrow_valid = 1'b0;
    arrow_mask  = '0;
    a = cyc;
    expect_pulse(g, clr, a + start + 5);
    for (int unsigned k = 1; k <= start + 5; k++) begin
      btn_lvl = (k >= start) ? press : 4'b0000;
      clear   = clr && (k == start + 5);
      step(1);
    end
    clear = 1'b0;
    step(1);
    chk("busy_after_grade", {31'b0, busy}, 32'd0);
    btn_lvl = '0;
    step(8);
  endtask

  // Monitor: every grade pulse is popped and compared against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [2:0] g;
    exp_t e;
    g = {hit_perfect, hit_good, miss};
    if (g != 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got grade=%b at cycle %0d, required no pulse", g, cyc);
      end else begin
        e = sb.pop_front();
        if (g !== e.grade || score !== e.score || combo !== e.combo || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse: got grade=%b score=%0d combo=%0d cycle=%0d, required grade=%b score=%0d combo=%0d cycle=%0d",
                   g, score, combo, cyc, e.grade, e.score, e.combo, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    errors++;
    $display("FAIL watchdog: stimulus did not complete within time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned a, b, base, j, t_last;
    logic [3:0] bits;
    reset = 1'b1;
    btn_lvl = '0;
    arrow_valid = 1'b0;
    arrow_mask = '0;
    clear = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_score", {16'b0, score}, 32'd0);
    chk("reset_combo", {24'b0, combo}, 32'd0);
    chk("reset_pulses", {29'b0, hit_perfect, hit_good, miss}, 32'd0);

    // Empty arrow mask is ignored.
    arrow_valid = 1'b1;
    arrow_mask = 4'b0000;
    step(1);
    arrow_valid = 1'b0;
    chk("mask0_ignored", {31'b0, busy}, 32'd0);

    // Glitchy up presses must not produce an edge; stable press grades at count 13.
    arrow_valid = 1'b1;
    arrow_mask = 4'b0001;
    step(1);
    arrow_valid = 1'b0;
    arrow_mask = '0;
    a = cyc;
    chk("busy_open", {31'b0, busy}, 32'd1);
    expect_pulse(G_P, 1'b0, a + 14);
    for (int unsigned k = 0; k < 8; k++) begin
      btn_lvl = ((k % 4) < 2) ? 4'b0001 : 4'b0000;
      step(1);
    end
    btn_lvl = 4'b0001;
    step(6);
    step(1);
    chk("busy_after_perfect", {31'b0, busy}, 32'd0);
    btn_lvl = '0;
    step(8);

    // Chord up+right: up edge at count 30, right edge at count 50 -> good.
    arrow_valid = 1'b1;
    arrow_mask = 4'b0101;
    step(1);
    arrow_valid = 1'b0;
    arrow_mask = '0;
    a = cyc;
    expect_pulse(G_G, 1'b0, a + 51);
    for (int unsigned k = 1; k <= 51; k++) begin
      btn_lvl = ((k >= 26) ? 4'b0001 : 4'b0000) | ((k >= 46) ? 4'b0100 : 4'b0000);
      step(1);
    end
    btn_lvl = '0;
    step(8);

    // No press: miss exactly 100 cycles after open.
    arrow_valid = 1'b1;
    arrow_mask = 4'b0001;
    step(1);
    arrow_valid = 1'b0;
    arrow_mask = '0;
    a = cyc;
    expect_pulse(G_M, 1'b0, a + 100);
    step(99);
    chk("busy_before_timeout", {31'b0, busy}, 32'd1);
    step(1);
    chk("busy_after_timeout", {31'b0, busy}, 32'd0);
    step(2);

    // Perfect then wrong press (down together with up) -> miss.
    press_arrow(4'b0001, 4'b0001, 3, G_P, 1'b0);
    press_arrow(4'b0001, 4'b0011, 1, G_M, 1'b0);

    // Overlap: replacing arrow at count 94 misses the first and restarts the window.
    arrow_valid = 1'b1;
    arrow_mask = 4'b0001;
    step(1);
    arrow_valid = 1'b0;
    arrow_mask = '0;
    a = cyc;
    expect_pulse(G_M, 1'b0, a + 95);
    step(94);
    arrow_valid = 1'b1;
    arrow_mask = 4'b1000;
    step(1);
    arrow_valid = 1'b0;
    arrow_mask = '0;
    b = cyc;
    chk("busy_overlap", {31'b0, busy}, 32'd1);
    expect_pulse(G_P, 1'b0, b + 6);
    btn_lvl = 4'b1000;
    step(6);
    step(1);
    chk("busy_after_overlap", {31'b0, busy}, 32'd0);
    btn_lvl = '0;
    step(8);

    // Clear coincident with the deciding cycle: pulse shows with zeroed totals.
    press_arrow(4'b0010, 4'b0010, 2, G_P, 1'b1);
    press_arrow(4'b0100, 4'b0100, 1, G_P, 1'b0);

    // Reset mid-window abandons the arrow silently.
    arrow_valid = 1'b1;
    arrow_mask = 4'b0001;
    step(1);
    arrow_valid = 1'b0;
    arrow_mask = '0;
    step(10);
    chk("busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step(1);
    chk("busy_reset_mid", {31'b0, busy}, 32'd0);
    chk("score_reset_mid", {16'b0, score}, 32'd0);
    chk("combo_reset_mid", {24'b0, combo}, 32'd0);
    reset = 1'b0;
    m_score = '0;
    m_combo = '0;
    step(3);

    // Staggered presses: one perfect every 2 cycles until score and combo saturate.
    base = cyc;
    t_last = 5 + 2 * (N_STREAM - 1);
    for (int unsigned t = 0; t <= t_last; t++) begin
      bits = '0;
      for (int unsigned d = 0; d < 4; d++) begin
        if (t >= 2 * d && ((t - 2 * d) % 8) < 4) bits[d] = 1'b1;
      end
      btn_lvl = bits;
      if (t >= 5 && ((t - 5) % 2) == 0) begin
        j = (t - 5) / 2;
        arrow_valid = 1'b1;
        arrow_mask = 4'b0001 << (j % 4);
        expect_pulse(G_P, 1'b0, base + t + 2);
      end else begin
        arrow_valid = 1'b0;
        arrow_mask = '0;
      end
      step(1);
    end
    arrow_valid = 1'b0;
    arrow_mask = '0;
    btn_lvl = '0;
    step(12);
    chk("score_saturated", {16'b0, score}, 32'h0000FFFF);
    chk("combo_saturated", {24'b0, combo}, 32'h000000FF);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
